// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state to the receiver state enum.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_rx_state_t;

    // Clock cycles per oversample tick (truncating divide).
    function automatic int unsigned uart_tick_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return clk_freq / (baud * UART_OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV
// cycles; restart holds the count at zero so the tick phase follows the caller.
module uart_baud_tick #(
    parameter int unsigned DIV = 162
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at DIV-1, forced to zero by restart.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: 16x oversampling 8N1 UART receiver with valid/ready holding
// register, framing/overrun reporting and, when UART_RX_PARITY_EN is defined,
// an even-parity bit with a parity_err pulse.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV = uart_tick_div(CLK_FREQ, BAUD_RATE);

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    logic [1:0]     sync_q;
    logic           rxs;
    logic           tick;
    logic           handshake;
    logic           vote_end;
    logic           vote_stop;
    logic           good;

    uart_rx_state_t state_q, state_d;
    logic [3:0]     scnt_q, scnt_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [2:0]     samp_q, samp_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           fe_q, fe_d;
    logic           ovr_q, ovr_d;
    logic           busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic           pbad_q, pbad_d;
    logic           pe_q, pe_d;
`endif

    assign rxs = sync_q[1];

    // Tick phase is pinned while idle, so counting starts fresh on START entry.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    // Two-flop synchroniser on the raw line, idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Next-state, sampling and frame evaluation.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bidx_d    = bidx_q;
        samp_d    = samp_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        fe_d      = 1'b0;
        good      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d    = pbad_q;
        pe_d      = 1'b0;
`endif
        handshake = valid_q && rx_ready;
        vote_end  = maj3(samp_q);
        // Stop is judged at sample 9 itself, so the live sample joins 7 and 8.
        vote_stop = maj3({rxs, samp_q[1:0]});

        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        if (tick) begin
            scnt_d = scnt_q + 4'd1;
            if (scnt_q == 4'd7) samp_d[0] = rxs;
            if (scnt_q == 4'd8) samp_d[1] = rxs;
            if (scnt_q == 4'd9) samp_d[2] = rxs;
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    scnt_d  = '0;
                    bidx_d  = '0;
`ifdef UART_RX_PARITY_EN
                    pbad_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (tick && scnt_q == 4'd15) begin
                    state_d = vote_end ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && scnt_q == 4'd15) begin
                    shreg_d = {vote_end, shreg_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && scnt_q == 4'd15) begin
                    pbad_d  = vote_end ^ (^shreg_q);
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && scnt_q == 4'd9) begin
                    fe_d = !vote_stop;
`ifdef UART_RX_PARITY_EN
                    pe_d = pbad_q;
                    good = vote_stop && !pbad_q;
`else
                    good = vote_stop;
`endif
                    if (good) begin
                        if (!valid_q || handshake) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Single state/output register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
            samp_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            samp_q  <= samp_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= pbad_d;
            pe_q    <= pe_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed bench for uart_rx_framed at 19200 baud with a
// 3.072 MHz clock (10 clocks per tick, 160 per bit). UART_RX_PARITY_EN adds
// the parity bit to every frame and the parity checks.
module tb_uart_rx_framed;

    localparam int DIV = 10;
    localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    int         acc_cnt = 0;
    int         valid_cyc = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    logic [7:0] acc_data = 8'h00;

    int b_acc, b_vc, b_fe, b_pe;

    uart_rx_framed #(.CLK_FREQ(3072000), .BAUD_RATE(19200)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid) valid_cyc++;
        if (rx_valid && rx_ready) begin
            acc_cnt++;
            acc_data = rx_data;
        end
        if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_acc = acc_cnt;
        b_vc  = valid_cyc;
        b_fe  = fe_cnt;
        b_pe  = pe_cnt;
    endtask

    // One frame; glitch_bit selects a data bit that gets a 10-cycle low pulse
    // covering only its middle (sample 8) point.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_bit, input int glitch_bit);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                hold(d[i], 85);
                hold(1'b0, 10);
                hold(d[i], BIT - 95);
            end else begin
                hold(d[i], BIT);
            end
        end
        if (PAR_EN) hold(par_bit, BIT);
        hold(stop_bit, BIT);
        rx = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 8'h00);
        check("reset_fe", frame_err, 0);
        check("reset_ovr", overrun, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hold(1'b1, 20);

        // Basic frame 0xA5
        snap();
        send_frame(8'hA5, 1'b1, ^8'hA5, -1);
        hold(1'b1, 40);
        check("basic_acc", acc_cnt - b_acc, 1);
        check("basic_valid_width", valid_cyc - b_vc, 1);
        check("basic_data", acc_data, 8'hA5);
        check("basic_fe", fe_cnt - b_fe, 0);
        check("basic_ovr", overrun, 0);
        check("basic_busy", busy, 0);

        // Overrun: 0x11 then 0x22 with no consumer
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11, -1);
        hold(1'b1, 40);
        check("ovr_first_valid", rx_valid, 1);
        check("ovr_first_flag", overrun, 0);
        send_frame(8'h22, 1'b1, ^8'h22, -1);
        hold(1'b1, 40);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_flag", overrun, 1);
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_clear_valid", rx_valid, 0);
        check("ovr_clear_flag", overrun, 0);
        check("ovr_clear_data", acc_data, 8'h11);
        hold(1'b1, 20);

        // Framing error on 0x3C, then a clean 0x5A
        snap();
        send_frame(8'h3C, 1'b0, ^8'h3C, -1);
        hold(1'b1, 2 * BIT);
        check("fe_pulse", fe_cnt - b_fe, 1);
        check("fe_no_valid", acc_cnt - b_acc, 0);
        check("fe_idle", busy, 0);
        snap();
        send_frame(8'h5A, 1'b1, ^8'h5A, -1);
        hold(1'b1, 40);
        check("after_fe_acc", acc_cnt - b_acc, 1);
        check("after_fe_data", acc_data, 8'h5A);
        check("after_fe_fe", fe_cnt - b_fe, 0);

        // Three-tick low glitch on idle line
        snap();
        hold(1'b0, 3 * DIV);
        @(negedge clk);
        check("glitch_busy", busy, 1);
        hold(1'b1, 200);
        check("glitch_idle", busy, 0);
        check("glitch_no_valid", acc_cnt - b_acc, 0);
        check("glitch_no_fe", fe_cnt - b_fe, 0);

        // Single-sample glitch inside bit 3 of 0xFF
        snap();
        send_frame(8'hFF, 1'b1, ^8'hFF, 3);
        hold(1'b1, 40);
        check("spike_acc", acc_cnt - b_acc, 1);
        check("spike_data", acc_data, 8'hFF);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        snap();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        hold(1'b1, 40);
        check("par_ok_acc", acc_cnt - b_acc, 1);
        check("par_ok_data", acc_data, 8'h07);
        check("par_ok_pe", pe_cnt - b_pe, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0, -1);
        hold(1'b1, 40);
        check("par_bad_pe", pe_cnt - b_pe, 1);
        check("par_bad_no_valid", acc_cnt - b_acc, 0);
        check("par_bad_fe", fe_cnt - b_fe, 0);
`endif

        // Reset asserted in the middle of data bit 4
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1, ^8'h99, -1);
        hold(1'b1, 40);
        check("pre_rst_valid", rx_valid, 1);
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, BIT);
        hold(1'b1, BIT / 2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mid_valid", rx_valid, 0);
        check("rst_mid_data", rx_data, 8'h00);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_fe", frame_err, 0);
        check("rst_mid_ovr", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rx_ready = 1'b1;
        snap();
        hold(1'b1, 2 * BIT);
        check("rst_mid_no_valid", acc_cnt - b_acc, 0);
        check("rst_mid_no_fe", fe_cnt - b_fe, 0);
        send_frame(8'hC3, 1'b1, ^8'hC3, -1);
        hold(1'b1, 40);
        check("rst_after_acc", acc_cnt - b_acc, 1);
        check("rst_after_data", acc_data, 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
